// File: rtl/serial_tc_sequencer_pkg.sv
// Shared types and sizing helpers for the serial two's-complement sequencer.
package serial_tc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Deepest cell latency the capture pipeline is built to cover.
    localparam int MAX_SER_LAT = 2;

    // Counter wide enough to hold any value 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_tc_sequencer_if.sv
// Valid/ready word streams into and out of the serial two's-complement sequencer.
interface serial_tc_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/serial_tc_sequencer_capture.sv
// Capture side of the sequencer: delays the per-bit valid by the cell latency
// and shifts the returning serial bits into a parallel word, MSB side in,
// so that bit j of the word ends up in cap_data[j].
module serial_tc_capture
    import serial_tc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SER_LAT = 0
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             clr,
    input  logic             bit_vld,
    input  logic             ser_y,
    output logic [WIDTH-1:0] cap_data
);
    localparam int LAT = (SER_LAT > MAX_SER_LAT) ? MAX_SER_LAT : SER_LAT;

    logic             sample_en;
    logic [WIDTH-1:0] cap_q, cap_d;

    generate
        if (LAT > 0) begin : g_dly
            logic [LAT-1:0] dly_q, dly_d;

            // Advance the bit-valid pipeline by one slot per clock.
            always_comb begin
                dly_d = (dly_q << 1) | LAT'(bit_vld);
            end

            // Bit-valid pipeline register, matched to the cell latency.
            always_ff @(posedge t_clk or posedge r) begin
                if (r) dly_q <= '0;
                else   dly_q <= dly_d;
            end

            assign sample_en = dly_q[LAT-1];
        end else begin : g_nodly
            assign sample_en = bit_vld;
        end
    endgenerate

    // Clear at the start of a word, otherwise shift in one result bit per valid slot.
    always_comb begin
        cap_d = cap_q;
        if (clr) begin
            cap_d = '0;
        end else if (sample_en) begin
            cap_d = {ser_y, cap_q[WIDTH-1:1]};
        end
    end

    // Capture register.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) cap_q <= '0;
        else   cap_q <= cap_d;
    end

    assign cap_data = cap_q;

endmodule

// File: rtl/serial_tc_sequencer.sv
// Serial two's-complement sequencer: accepts a word, clocks it LSB first
// through the external serial negation cell, reassembles the result and
// holds it until the consumer takes it. One word in flight at a time.
// Optional macro SERTC_OVF_FLAG_EN adds the ovf output (operand was the most
// negative value, so its negation is unrepresentable).
module serial_tc_sequencer
    import serial_tc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SER_LAT = 0
) (
    input  logic                  t_clk,
    input  logic                  r,
    serial_tc_sequencer_if.slave  bus,
    output logic                  busy,
    output logic                  ser_i,
    output logic                  ser_r,
    input  logic                  ser_y
`ifdef SERTC_OVF_FLAG_EN
    ,
    output logic                  ovf
`endif
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             accept;
    logic             out_hs;
    logic             in_ready;
    logic             out_valid;
    logic             bit_vld;
    logic [WIDTH-1:0] cap_data;

    // Next-state, serializer and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ser_i     = 1'b0;
        ser_r     = 1'b0;
        accept    = 1'b0;
        out_hs    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                ser_r    = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    sh_d    = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_i = sh_q[0];
                ser_r = (cnt_q == '0);
                sh_d  = sh_q >> 1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = (SER_LAT > 0) ? DRAIN : HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Wait for the last bits still inside the cell.
                if (cnt_q == CNT_W'(SER_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    out_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, bit counter and operand shift register.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    assign bit_vld       = (state_q == SHIFT);
    assign busy          = (state_q != IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = cap_data;

    serial_tc_capture #(
        .WIDTH   (WIDTH),
        .SER_LAT (SER_LAT)
    ) u_capture (
        .t_clk    (t_clk),
        .r        (r),
        .clr      (accept),
        .bit_vld  (bit_vld),
        .ser_y    (ser_y),
        .cap_data (cap_data)
    );

`ifdef SERTC_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Flag the most negative operand at accept; drop it when the result is taken.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = (bus.in_data == {1'b1, {(WIDTH-1){1'b0}}});
        end else if (out_hs) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) ovf_q <= 1'b0;
        else   ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule
